// File: rtl/ro_entropy_sampler.sv
// Ring-oscillator entropy harvester: synchronise and XOR the oscillators, decimate,
// von Neumann debias, and pack the surviving bits into words behind a valid/ready handshake.
module ro_entropy_sampler #(
    parameter int unsigned RO_COUNT      = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DECIMATION    = 8,
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter int unsigned WORD_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  enable,
    input  logic [RO_COUNT-1:0]   roIn,
    output logic                  roEnable,
    output logic [WORD_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    input  logic                  dataReady,
    output logic                  overflow
);

    localparam int unsigned DecW  = $clog2(DECIMATION + 1);
    localparam int unsigned WarmW = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned CntW  = $clog2(WORD_WIDTH + 1);

    localparam logic [DecW-1:0]  DecLast  = DecW'(DECIMATION - 1);
    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

    state_e                state_q, state_d;
    logic [RO_COUNT-1:0]   sync_q [SYNC_STAGES];
    logic [RO_COUNT-1:0]   sync_d [SYNC_STAGES];
    logic [WarmW-1:0]      warm_q, warm_d;
    logic [DecW-1:0]       dec_q, dec_d;
    logic                  have_first_q, have_first_d;
    logic                  first_q, first_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  ro_en_q, ro_en_d;

    logic                  raw_bit;
    logic                  sample;
    logic                  emit;
    logic                  word_done;
    logic [WORD_WIDTH-1:0] new_acc;

    assign raw_bit = ^sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = roIn;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        warm_d       = warm_q;
        dec_d        = dec_q;
        have_first_d = have_first_q;
        first_d      = first_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;
        sample       = 1'b0;
        emit         = 1'b0;
        word_done    = 1'b0;
        new_acc      = {acc_q[WORD_WIDTH-2:0], first_q};

        if (!enable) begin
            // Dropping enable discards all partial harvest state; a pending word survives.
            state_d      = StIdle;
            warm_d       = '0;
            dec_d        = '0;
            have_first_d = 1'b0;
            first_d      = 1'b0;
            acc_d        = '0;
            bit_cnt_d    = '0;
            ovf_d        = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWarmup;
                    warm_d  = '0;
                end
                StWarmup: begin
                    if (warm_q == WarmLast) begin
                        state_d = StRun;
                        dec_d   = '0;
                    end else begin
                        warm_d = warm_q + 1'b1;
                    end
                end
                StRun: begin
                    if (dec_q == DecLast) begin
                        dec_d  = '0;
                        sample = 1'b1;
                    end else begin
                        dec_d = dec_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Von Neumann: a differing pair emits its first bit (10 -> 1, 01 -> 0).
        if (sample) begin
            if (!have_first_q) begin
                have_first_d = 1'b1;
                first_d      = raw_bit;
            end else begin
                have_first_d = 1'b0;
                emit         = (first_q != raw_bit);
            end
        end

        if (emit) begin
            acc_d = new_acc;
            if (bit_cnt_q == CntLast) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (word_done && (!valid_q || dataReady)) begin
            data_d  = new_acc;
            valid_d = 1'b1;
        end else if (word_done) begin
            ovf_d = 1'b1;
        end else if (valid_q && dataReady) begin
            valid_d = 1'b0;
        end

        ro_en_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= StIdle;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            warm_q       <= '0;
            dec_q        <= '0;
            have_first_q <= 1'b0;
            first_q      <= 1'b0;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            ro_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
            warm_q       <= warm_d;
            dec_q        <= dec_d;
            have_first_q <= have_first_d;
            first_q      <= first_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            ro_en_q      <= ro_en_d;
        end
    end

    assign roEnable  = ro_en_q;
    assign dataOut   = data_q;
    assign dataValid = valid_q;
    assign overflow  = ovf_q;

endmodule
